// File: rtl/ysyx_24100006_axi_rd_arbiter.sv
// 2-to-1 AXI read arbiter (IFU bursts, LSU single beats) in front of ysyx_24100006_axi.
// Define ARB_RR_EN to replace fixed LSU priority with round-robin on simultaneous requests.
module ysyx_24100006_axi_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ifu_arvalid_i,
    output logic              ifu_arready_o,
    input  logic [ADDR_W-1:0] ifu_araddr_i,
    input  logic [7:0]        ifu_arlen_i,
    output logic              ifu_rvalid_o,
    input  logic              ifu_rready_i,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic [1:0]        ifu_rresp_o,
    output logic              ifu_rlast_o,

    input  logic              lsu_arvalid_i,
    output logic              lsu_arready_o,
    input  logic [ADDR_W-1:0] lsu_araddr_i,
    input  logic [2:0]        lsu_arsize_i,
    output logic              lsu_rvalid_o,
    input  logic              lsu_rready_i,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic [1:0]        lsu_rresp_o,

    output logic              axi_arvalid_o,
    input  logic              axi_arready_i,
    output logic [ADDR_W-1:0] axi_araddr_o,
    output logic [7:0]        axi_arlen_o,
    output logic [2:0]        axi_arsize_o,
    input  logic              axi_rvalid_i,
    output logic              axi_rready_o,
    input  logic [DATA_W-1:0] axi_rdata_i,
    input  logic [1:0]        axi_rresp_i,
    input  logic              axi_rlast_i
);

    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned LEN_W    = 8;
    localparam logic [SIZE_W-1:0] IFU_SIZE = SIZE_W'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IFU = 2'd1,
        GNT_LSU = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ar_done;
    logic   any_req;
    logic   pick_lsu;
    logic   ar_hs;
    logic   r_last_hs;

    assign any_req   = ifu_arvalid_i | lsu_arvalid_i;
    assign ar_hs     = axi_arvalid_o & axi_arready_i;
    assign r_last_hs = axi_rvalid_i & axi_rready_o & axi_rlast_i;

`ifdef ARB_RR_EN
    // last_lsu == 0 means the IFU held the most recent grant
    logic last_lsu;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_lsu <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_lsu <= pick_lsu;
        end
    end

    assign pick_lsu = lsu_arvalid_i & (~ifu_arvalid_i | ~last_lsu);
`else
    assign pick_lsu = lsu_arvalid_i;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant on any request, release after the last R beat
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = pick_lsu ? GNT_LSU : GNT_IFU;
                end
            end
            GNT_IFU, GNT_LSU: begin
                if (r_last_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // AR is issued once per grant; a master still holding arvalid is ignored afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_done <= 1'b0;
        end else if (state == IDLE) begin
            ar_done <= 1'b0;
        end else if (ar_hs) begin
            ar_done <= 1'b1;
        end
    end

    // Read data and response are broadcast; only rvalid is steered
    assign ifu_rdata_o = axi_rdata_i;
    assign ifu_rresp_o = axi_rresp_i;
    assign lsu_rdata_o = axi_rdata_i;
    assign lsu_rresp_o = axi_rresp_i;

    // Channel muxing driven by the current grant
    always_comb begin
        axi_arvalid_o = 1'b0;
        axi_araddr_o  = '0;
        axi_arlen_o   = '0;
        axi_arsize_o  = '0;
        axi_rready_o  = 1'b0;
        ifu_arready_o = 1'b0;
        ifu_rvalid_o  = 1'b0;
        ifu_rlast_o   = 1'b0;
        lsu_arready_o = 1'b0;
        lsu_rvalid_o  = 1'b0;
        case (state)
            GNT_IFU: begin
                axi_arvalid_o = ifu_arvalid_i & ~ar_done;
                axi_araddr_o  = ifu_araddr_i;
                axi_arlen_o   = ifu_arlen_i;
                axi_arsize_o  = IFU_SIZE;
                ifu_arready_o = axi_arready_i & ~ar_done;
                ifu_rvalid_o  = axi_rvalid_i;
                axi_rready_o  = ifu_rready_i;
                ifu_rlast_o   = axi_rlast_i;
            end
            GNT_LSU: begin
                axi_arvalid_o = lsu_arvalid_i & ~ar_done;
                axi_araddr_o  = lsu_araddr_i;
                axi_arlen_o   = LEN_W'(0);
                axi_arsize_o  = lsu_arsize_i;
                lsu_arready_o = axi_arready_i & ~ar_done;
                lsu_rvalid_o  = axi_rvalid_i;
                axi_rready_o  = lsu_rready_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100006_axi_rd_arbiter.sv
// Randomized bench for ysyx_24100006_axi_rd_arbiter: bench-side masters and memory slave,
// checked cycle by cycle against a transaction-level arbitration model.
module tb_ysyx_24100006_axi_rd_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              ifu_arvalid_i;
    logic              ifu_arready_o;
    logic [ADDR_W-1:0] ifu_araddr_i;
    logic [7:0]        ifu_arlen_i;
    logic              ifu_rvalid_o;
    logic              ifu_rready_i;
    logic [DATA_W-1:0] ifu_rdata_o;
    logic [1:0]        ifu_rresp_o;
    logic              ifu_rlast_o;
    logic              lsu_arvalid_i;
    logic              lsu_arready_o;
    logic [ADDR_W-1:0] lsu_araddr_i;
    logic [2:0]        lsu_arsize_i;
    logic              lsu_rvalid_o;
    logic              lsu_rready_i;
    logic [DATA_W-1:0] lsu_rdata_o;
    logic [1:0]        lsu_rresp_o;
    logic              axi_arvalid_o;
    logic              axi_arready_i;
    logic [ADDR_W-1:0] axi_araddr_o;
    logic [7:0]        axi_arlen_o;
    logic [2:0]        axi_arsize_o;
    logic              axi_rvalid_i;
    logic              axi_rready_o;
    logic [DATA_W-1:0] axi_rdata_i;
    logic [1:0]        axi_rresp_i;
    logic              axi_rlast_i;

    ysyx_24100006_axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .ifu_arvalid_i(ifu_arvalid_i), .ifu_arready_o(ifu_arready_o),
        .ifu_araddr_i(ifu_araddr_i), .ifu_arlen_i(ifu_arlen_i),
        .ifu_rvalid_o(ifu_rvalid_o), .ifu_rready_i(ifu_rready_i),
        .ifu_rdata_o(ifu_rdata_o), .ifu_rresp_o(ifu_rresp_o), .ifu_rlast_o(ifu_rlast_o),
        .lsu_arvalid_i(lsu_arvalid_i), .lsu_arready_o(lsu_arready_o),
        .lsu_araddr_i(lsu_araddr_i), .lsu_arsize_i(lsu_arsize_i),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rready_i(lsu_rready_i),
        .lsu_rdata_o(lsu_rdata_o), .lsu_rresp_o(lsu_rresp_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o), .axi_arsize_o(axi_arsize_o),
        .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
        .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i), .axi_rlast_i(axi_rlast_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner 0 = none, 1 = IFU, 2 = LSU
    int m_owner;
    int m_last;
    bit m_acc;

    logic              e_axi_arvalid, e_axi_rready, e_ifu_arready, e_ifu_rvalid, e_ifu_rlast;
    logic              e_lsu_arready, e_lsu_rvalid;
    logic [ADDR_W-1:0] e_axi_araddr;
    logic [7:0]        e_axi_arlen;
    logic [2:0]        e_axi_arsize;

    int ifu_st, ifu_left, lsu_st, lsu_left, s_left;
    int ifu_done, lsu_done, ifu_beats;
    bit lsu_rereq;
    logic [1:0] lsu_resp_seen;
    int unsigned ifu_pct, lsu_pct, rready_pct, arready_pct, rvalid_pct, reset_permil;
    int force_resp;
    logic [ADDR_W-1:0] ar_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int winner(input bit ifu_req, input bit lsu_req, input int last);
        if (ifu_req && lsu_req) begin
`ifdef ARB_RR_EN
            return (last == 2) ? 1 : 2;
`else
            return 2;
`endif
        end
        return lsu_req ? 2 : 1;
    endfunction

    task automatic predict();
        e_axi_arvalid = 1'b0; e_axi_araddr = '0; e_axi_arlen = '0; e_axi_arsize = '0;
        e_axi_rready  = 1'b0; e_ifu_arready = 1'b0; e_ifu_rvalid = 1'b0; e_ifu_rlast = 1'b0;
        e_lsu_arready = 1'b0; e_lsu_rvalid = 1'b0;
        if (m_owner == 1) begin
            e_axi_arvalid = ifu_arvalid_i & ~m_acc;
            e_axi_araddr  = ifu_araddr_i;
            e_axi_arlen   = ifu_arlen_i;
            e_axi_arsize  = 3'd2;
            e_ifu_arready = axi_arready_i & ~m_acc;
            e_ifu_rvalid  = axi_rvalid_i;
            e_axi_rready  = ifu_rready_i;
            e_ifu_rlast   = axi_rlast_i;
        end else if (m_owner == 2) begin
            e_axi_arvalid = lsu_arvalid_i & ~m_acc;
            e_axi_araddr  = lsu_araddr_i;
            e_axi_arsize  = lsu_arsize_i;
            e_lsu_arready = axi_arready_i & ~m_acc;
            e_lsu_rvalid  = axi_rvalid_i;
            e_axi_rready  = lsu_rready_i;
        end
    endtask

    task automatic check_outputs();
        chk("arvalid",    32'(axi_arvalid_o), 32'(e_axi_arvalid));
        chk("araddr",     32'(axi_araddr_o),  32'(e_axi_araddr));
        chk("arlen",      32'(axi_arlen_o),   32'(e_axi_arlen));
        chk("arsize",     32'(axi_arsize_o),  32'(e_axi_arsize));
        chk("rready",     32'(axi_rready_o),  32'(e_axi_rready));
        chk("ifu_arready", 32'(ifu_arready_o), 32'(e_ifu_arready));
        chk("ifu_rvalid", 32'(ifu_rvalid_o),  32'(e_ifu_rvalid));
        chk("ifu_rlast",  32'(ifu_rlast_o),   32'(e_ifu_rlast));
        chk("lsu_arready", 32'(lsu_arready_o), 32'(e_lsu_arready));
        chk("lsu_rvalid", 32'(lsu_rvalid_o),  32'(e_lsu_rvalid));
        chk("ifu_rdata",  32'(ifu_rdata_o),   32'(axi_rdata_i));
        chk("lsu_rdata",  32'(lsu_rdata_o),   32'(axi_rdata_i));
        chk("ifu_rresp",  32'(ifu_rresp_o),   32'(axi_rresp_i));
        chk("lsu_rresp",  32'(lsu_rresp_o),   32'(axi_rresp_i));
        if (e_ifu_rvalid && ifu_rready_i) begin
            chk("ifu_last_beat", 32'(ifu_rlast_o), 32'(ifu_left == 1));
        end
        if (e_lsu_rvalid && lsu_rready_i) begin
            lsu_resp_seen = lsu_rresp_o;
        end
    endtask

    task automatic start_ifu(input logic [ADDR_W-1:0] a, input logic [7:0] len);
        ifu_arvalid_i = 1'b1; ifu_araddr_i = a; ifu_arlen_i = len; ifu_st = 1;
    endtask

    task automatic start_lsu(input logic [ADDR_W-1:0] a, input logic [2:0] size);
        lsu_arvalid_i = 1'b1; lsu_araddr_i = a; lsu_arsize_i = size; lsu_st = 1;
    endtask

    // Advance model, masters and slave across the edge just taken
    task automatic update();
        if (reset) begin
            m_owner = 0; m_acc = 1'b0; m_last = 1;
            ifu_st = 0; lsu_st = 0; ifu_left = 0; lsu_left = 0; s_left = 0;
            ifu_arvalid_i = 1'b0; lsu_arvalid_i = 1'b0; lsu_rereq = 1'b0;
            axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
        end else begin
            if (m_owner == 0) begin
                if (ifu_arvalid_i || lsu_arvalid_i) begin
                    m_owner = winner(ifu_arvalid_i, lsu_arvalid_i, m_last);
                    m_last  = m_owner;
                    m_acc   = 1'b0;
                end
            end else begin
                if (e_axi_arvalid && axi_arready_i) m_acc = 1'b1;
                if (axi_rvalid_i && e_axi_rready && axi_rlast_i) m_owner = 0;
            end
            if (axi_rvalid_i && e_axi_rready) begin
                s_left--;
                axi_rvalid_i = 1'b0;
            end
            if (e_axi_arvalid && axi_arready_i) begin
                ar_log.push_back(e_axi_araddr);
                s_left = int'(e_axi_arlen) + 1;
            end
            if (ifu_arvalid_i && e_ifu_arready) begin
                ifu_arvalid_i = 1'b0; ifu_st = 2; ifu_left = int'(ifu_arlen_i) + 1;
            end else if (e_ifu_rvalid && ifu_rready_i) begin
                ifu_left--; ifu_beats++;
                if (ifu_left == 0) begin ifu_st = 0; ifu_done++; end
            end
            if (lsu_arvalid_i && e_lsu_arready) begin
                lsu_arvalid_i = 1'b0; lsu_st = 2; lsu_left = 1;
            end else if (e_lsu_rvalid && lsu_rready_i) begin
                lsu_left--;
                if (lsu_left == 0) begin
                    lsu_st = 0; lsu_done++;
                    if (lsu_rereq) begin
                        lsu_rereq = 1'b0;
                        start_lsu(32'h0f00_0020, 3'd0);
                    end
                end
            end
        end
    endtask

    task automatic drive();
        reset = ($urandom_range(0, 999) < reset_permil);
        if (ifu_st == 0 && $urandom_range(0, 99) < ifu_pct)
            start_ifu($urandom, 8'($urandom_range(0, 7)));
        if (lsu_st == 0 && $urandom_range(0, 99) < lsu_pct)
            start_lsu($urandom, 3'($urandom_range(0, 2)));
        ifu_rready_i  = ($urandom_range(0, 99) < rready_pct);
        lsu_rready_i  = ($urandom_range(0, 99) < rready_pct);
        axi_arready_i = ($urandom_range(0, 99) < arready_pct);
        if (s_left > 0 && !axi_rvalid_i && $urandom_range(0, 99) < rvalid_pct) begin
            axi_rvalid_i = 1'b1;
            axi_rdata_i  = $urandom;
            axi_rresp_i  = (force_resp >= 0) ? 2'(force_resp) : 2'($urandom_range(0, 3));
            axi_rlast_i  = (s_left == 1);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        predict();
        check_outputs();
        @(posedge clk);
        #1;
        update();
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        ar_log.delete();
    endtask

    task automatic full_ready();
        ifu_pct = 0; lsu_pct = 0; reset_permil = 0; force_resp = -1;
        rready_pct = 100; arready_pct = 100; rvalid_pct = 100;
    endtask

    int i0, l0, b0;
    logic [ADDR_W-1:0] exp2, exp3;

    initial begin
        reset = 1'b1;
        ifu_arvalid_i = 1'b0; ifu_araddr_i = '0; ifu_arlen_i = '0; ifu_rready_i = 1'b0;
        lsu_arvalid_i = 1'b0; lsu_araddr_i = '0; lsu_arsize_i = '0; lsu_rready_i = 1'b0;
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b0; axi_rdata_i = '0; axi_rresp_i = '0;
        axi_rlast_i = 1'b0;
        m_owner = 0; m_acc = 1'b0; m_last = 1;
        ifu_st = 0; lsu_st = 0; ifu_left = 0; lsu_left = 0; s_left = 0;
        ifu_done = 0; lsu_done = 0; ifu_beats = 0; lsu_rereq = 1'b0; lsu_resp_seen = '0;
        full_ready();
        @(posedge clk);
        #1;
        do_reset();

        // IFU alone, 4-beat burst
        i0 = ifu_done; l0 = lsu_done; b0 = ifu_beats;
        start_ifu(32'h3000_0000, 8'd3);
        repeat (14) cycle();
        chk("a_nar", 32'(ar_log.size()), 32'd1);
        if (ar_log.size() >= 1) chk("a_addr", ar_log[0], 32'h3000_0000);
        chk("a_beats", 32'(ifu_beats - b0), 32'd4);
        chk("a_ifu_done", 32'(ifu_done - i0), 32'd1);
        chk("a_lsu_done", 32'(lsu_done - l0), 32'd0);

        // Simultaneous requests, LSU re-requests immediately after its beat
        do_reset();
        start_ifu(32'h3000_0000, 8'd3);
        start_lsu(32'h0f00_0010, 3'd0);
        lsu_rereq = 1'b1;
        repeat (40) cycle();
`ifdef ARB_RR_EN
        exp2 = 32'h3000_0000; exp3 = 32'h0f00_0020;
`else
        exp2 = 32'h0f00_0020; exp3 = 32'h3000_0000;
`endif
        chk("b_nar", 32'(ar_log.size()), 32'd3);
        if (ar_log.size() >= 3) begin
            chk("b_first", ar_log[0], 32'h0f00_0010);
            chk("b_second", ar_log[1], exp2);
            chk("b_third", ar_log[2], exp3);
        end

        // AR and R backpressure on an LSU read
        do_reset();
        l0 = lsu_done;
        arready_pct = 0;
        start_lsu(32'h0f00_0010, 3'd0);
        repeat (6) cycle();
        chk("c_noar", 32'(ar_log.size()), 32'd0);
        arready_pct = 100; rready_pct = 0;
        repeat (5) cycle();
        chk("c_stall", 32'(lsu_done - l0), 32'd0);
        rready_pct = 100;
        repeat (4) cycle();
        chk("c_done", 32'(lsu_done - l0), 32'd1);

        // Reset in the middle of an IFU burst, then a fresh LSU read
        do_reset();
        b0 = ifu_beats;
        start_ifu(32'h3000_0000, 8'd3);
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (ifu_beats - b0 >= 2) break;
        end
        chk("d_beats", 32'(ifu_beats - b0), 32'd2);
        do_reset();
        l0 = lsu_done;
        start_lsu(32'h0f00_0030, 3'd2);
        repeat (8) cycle();
        chk("d_lsu_done", 32'(lsu_done - l0), 32'd1);

        // SLVERR on an LSU read, followed by an IFU read
        do_reset();
        force_resp = 2;
        l0 = lsu_done; i0 = ifu_done;
        start_lsu(32'h0f00_0040, 3'd2);
        repeat (6) cycle();
        chk("e_lsu_done", 32'(lsu_done - l0), 32'd1);
        chk("e_resp", 32'(lsu_resp_seen), 32'd2);
        force_resp = -1;
        start_ifu(32'h3000_0100, 8'd1);
        repeat (12) cycle();
        chk("e_ifu_done", 32'(ifu_done - i0), 32'd1);

        // Random traffic with varying pressure
        i0 = ifu_done; l0 = lsu_done;
        for (int p = 0; p < 4; p++) begin
            ifu_pct      = $urandom_range(10, 90);
            lsu_pct      = $urandom_range(10, 90);
            rready_pct   = $urandom_range(30, 100);
            arready_pct  = $urandom_range(30, 100);
            rvalid_pct   = $urandom_range(30, 100);
            reset_permil = (p == 3) ? 3 : 0;
            repeat (1500) cycle();
        end
        full_ready();
        repeat (100) cycle();
        chk("rnd_ifu_prog", 32'(ifu_done > i0), 32'd1);
        chk("rnd_lsu_prog", 32'(lsu_done > l0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
